// File: rtl/multicycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_if
//   Shared memory-bus handshake between the multi-cycle control unit and the
//   memory system. A single port carries either an instruction fetch or a data
//   access; the requester holds its request until io_bus_ready is seen.
//
//   Signals:
//     io_fetch_request  master->slave  instruction read request
//     io_data_request   master->slave  data access request
//     io_data_write     master->slave  data access is a store (with io_data_request)
//     io_bus_ready      slave->master  acknowledge for the current request
// -----------------------------------------------------------------------------
interface multicycle_control_unit_if;
  logic io_fetch_request;
  logic io_data_request;
  logic io_data_write;
  logic io_bus_ready;

  modport master (
    output io_fetch_request,
    output io_data_request,
    output io_data_write,
    input  io_bus_ready
  );

  modport slave (
    input  io_fetch_request,
    input  io_data_request,
    input  io_data_write,
    output io_bus_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//   Sequencer for the multi-cycle RISC-V core. Steps every instruction through
//   FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, arbitrates the shared memory
//   bus between instruction fetch and data access with a bounded wait, and
//   produces the per-phase strobes plus a retired-instruction counter.
//
//   Ports:
//     clock, reset            core clock, synchronous active-high reset
//     io_halt                 debug halt (honoured only in IDLE and at retire)
//     io_memory_read_enable   decoder: load
//     io_memory_write_enable  decoder: store
//     io_reg_write_enable     decoder: rd write
//     bus                     shared memory bus (fetch/data request, ready)
//     io_ir_write_enable      latch the fetched instruction
//     io_reg_write_commit     register-file write strobe
//     io_pc_write_enable      PC update strobe (retire cycle)
//     io_instret              one-cycle pulse per retired instruction
//     io_instret_count        retired-instruction count (wraps)
//     io_state                current state encoding
//     io_bus_error            sticky bus-timeout / illegal-control flag
//
//   MEM_TIMEOUT: number of consecutive un-acknowledged request cycles after
//   which the unit gives up and enters ERROR (must be >= 1).
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              io_halt,
  input  logic                              io_memory_read_enable,
  input  logic                              io_memory_write_enable,
  input  logic                              io_reg_write_enable,
  multicycle_control_unit_if.master         bus,
  output logic                              io_ir_write_enable,
  output logic                              io_reg_write_commit,
  output logic                              io_pc_write_enable,
  output logic                              io_instret,
  output logic [31:0]                       io_instret_count,
  output logic [2:0]                        io_state,
  output logic                              io_bus_error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  // The counter only ever holds 0..MEM_TIMEOUT-1; the cycle that would reach
  // MEM_TIMEOUT goes to ERROR instead.
  localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_reg_write;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [31:0]      r_instret_count;

  state_t           w_next_state;
  logic             w_fetch_req;
  logic             w_data_req;
  logic             w_data_write;
  logic             w_ir_we;
  logic             w_commit;
  logic             w_retire;
  logic             w_wait_inc;
  logic             w_timeout;

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_reg_write     <= 1'b0;
      r_wait_cnt      <= '0;
      r_instret_count <= '0;
    end else begin
      r_state <= w_next_state;
      // Decoder outputs are only trusted during DECODE; later phases use
      // these copies so the decoder may move on.
      if (r_state == S_DECODE) begin
        r_mem_read  <= io_memory_read_enable;
        r_mem_write <= io_memory_write_enable;
        r_reg_write <= io_reg_write_enable;
      end
      // Clearing in every non-waiting cycle also covers "clear on entry".
      r_wait_cnt <= w_wait_inc ? r_wait_cnt + 1'b1 : '0;
      if (w_retire) begin
        r_instret_count <= r_instret_count + 32'd1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_fetch_req  = 1'b0;
    w_data_req   = 1'b0;
    w_data_write = 1'b0;
    w_ir_we      = 1'b0;
    w_commit     = 1'b0;
    w_retire     = 1'b0;
    w_wait_inc   = 1'b0;
    w_timeout    = (r_wait_cnt == WAIT_LAST);

    unique case (r_state)
      S_IDLE: begin
        w_next_state = io_halt ? S_HALTED : S_FETCH;
      end
      S_FETCH: begin
        w_fetch_req = 1'b1;
        if (bus.io_bus_ready) begin
          w_ir_we      = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_DECODE: begin
        w_next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (r_mem_read && r_mem_write) begin
          w_next_state = S_ERROR;
        end else if (r_mem_read || r_mem_write) begin
          w_next_state = S_MEMORY;
        end else if (r_reg_write) begin
          w_next_state = S_WRITEBACK;
        end else begin
          w_retire = 1'b1;
        end
      end
      S_MEMORY: begin
        w_data_req   = 1'b1;
        w_data_write = r_mem_write;
        if (bus.io_bus_ready) begin
          if (r_mem_write) begin
            w_retire = 1'b1;
          end else begin
            w_next_state = S_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_WRITEBACK: begin
        w_commit = r_reg_write;
        w_retire = 1'b1;
      end
      S_HALTED: begin
        w_next_state = io_halt ? S_HALTED : S_FETCH;
      end
      S_ERROR: begin
        w_next_state = S_ERROR;
      end
      default: begin
        w_next_state = S_ERROR;
      end
    endcase

    // Halt is only looked at between instructions.
    if (w_retire) begin
      w_next_state = io_halt ? S_HALTED : S_FETCH;
    end
  end

  // Every output is forced low during the reset cycle, including those that
  // follow io_bus_ready combinationally, so an abandoned transaction drops
  // its request immediately.
  assign bus.io_fetch_request = w_fetch_req  & ~reset;
  assign bus.io_data_request  = w_data_req   & ~reset;
  assign bus.io_data_write    = w_data_write & ~reset;
  assign io_ir_write_enable   = w_ir_we      & ~reset;
  assign io_reg_write_commit  = w_commit     & ~reset;
  assign io_pc_write_enable   = w_retire     & ~reset;
  assign io_instret           = w_retire     & ~reset;
  assign io_instret_count     = reset ? 32'd0 : r_instret_count;
  assign io_state             = reset ? 3'd0  : r_state;
  assign io_bus_error         = (r_state == S_ERROR) & ~reset;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
//   Instruction-level model: each task emits the per-cycle stimulus and the
//   expected outputs implied by the instruction's phase latencies; one compare
//   process checks every cycle. A few literal pins anchor the model.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic [2:0]  state;
    logic        fr;
    logic        dr;
    logic        dw;
    logic        ir;
    logic        cm;
    logic        pc;
    logic        ins;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        io_halt;
  logic        io_memory_read_enable;
  logic        io_memory_write_enable;
  logic        io_reg_write_enable;
  logic        io_ir_write_enable;
  logic        io_reg_write_commit;
  logic        io_pc_write_enable;
  logic        io_instret;
  logic [31:0] io_instret_count;
  logic [2:0]  io_state;
  logic        io_bus_error;

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(.MEM_TIMEOUT(TO)) dut (
    .clock                  (clk),
    .reset                  (reset),
    .io_halt                (io_halt),
    .io_memory_read_enable  (io_memory_read_enable),
    .io_memory_write_enable (io_memory_write_enable),
    .io_reg_write_enable    (io_reg_write_enable),
    .bus                    (bus),
    .io_ir_write_enable     (io_ir_write_enable),
    .io_reg_write_commit    (io_reg_write_commit),
    .io_pc_write_enable     (io_pc_write_enable),
    .io_instret             (io_instret),
    .io_instret_count       (io_instret_count),
    .io_state               (io_state),
    .io_bus_error           (io_bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] m_count;
  logic        m_rd, m_wr, m_rw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: one expected record per stimulated cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check("state",         {29'd0, io_state},             {29'd0, cur.state});
      check("fetch_request", {31'd0, bus.io_fetch_request}, {31'd0, cur.fr});
      check("data_request",  {31'd0, bus.io_data_request},  {31'd0, cur.dr});
      check("data_write",    {31'd0, bus.io_data_write},    {31'd0, cur.dw});
      check("ir_write",      {31'd0, io_ir_write_enable},   {31'd0, cur.ir});
      check("reg_commit",    {31'd0, io_reg_write_commit},  {31'd0, cur.cm});
      check("pc_write",      {31'd0, io_pc_write_enable},   {31'd0, cur.pc});
      check("instret",       {31'd0, io_instret},           {31'd0, cur.ins});
      check("instret_count", io_instret_count,              cur.cnt);
      check("bus_error",     {31'd0, io_bus_error},         {31'd0, cur.err});
    end
  end

  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e       = '0;
    e.state = st;
    e.cnt   = m_count;
    return e;
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue its expectation.
  task automatic step(input logic rdy, input logic hlt, input logic rst, input exp_t e);
    @(posedge clk);
    #1;
    reset                  = rst;
    io_halt                = hlt;
    bus.io_bus_ready       = rdy;
    io_memory_read_enable  = m_rd;
    io_memory_write_enable = m_wr;
    io_reg_write_enable    = m_rw;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, exp_t'('0));
    m_count = 32'd0;
  endtask

  task automatic idle(input logic hlt);
    step(1'b1, hlt, 1'b0, base(3'd0));
  endtask

  task automatic halted(input logic hlt);
    step(1'b1, hlt, 1'b0, base(3'd6));
  endtask

  task automatic err(input int n);
    exp_t e;
    e = base(3'd7);
    e.err = 1'b1;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, e);
  endtask

  // One instruction: fw wait cycles in fetch, mw wait cycles in memory, halt
  // driven from EXECUTE onward; abort >= 0 stops after that many stalled
  // memory cycles.
  task automatic instr(input logic rd, input logic wr, input logic rw,
                       input int fw, input int mw, input logic hlt, input int abort);
    exp_t e;
    int   n;
    logic last;
    m_rd = rd; m_wr = wr; m_rw = rw;
    for (int i = 0; i <= fw; i++) begin
      e = base(3'd1);
      e.fr = 1'b1;
      e.ir = (i == fw);
      step(i == fw, 1'b0, 1'b0, e);
    end
    step(1'b1, 1'b0, 1'b0, base(3'd2));
    // Decoder moves on after DECODE; the unit must use its latched copy.
    m_rd = ~rd; m_wr = ~wr; m_rw = ~rw;
    e = base(3'd3);
    if (rd && wr) begin
      step(1'b1, hlt, 1'b0, e);
      return;
    end
    if (!rd && !wr && !rw) begin
      e.pc = 1'b1; e.ins = 1'b1;
      step(1'b1, hlt, 1'b0, e);
      m_count++;
      return;
    end
    step(1'b1, hlt, 1'b0, e);
    if (rd || wr) begin
      n = (abort >= 0) ? abort : mw + 1;
      for (int i = 0; i < n; i++) begin
        last = (abort < 0) && (i == mw);
        e = base(3'd4);
        e.dr = 1'b1;
        e.dw = wr;
        if (last && wr) begin
          e.pc = 1'b1; e.ins = 1'b1;
        end
        step(last, hlt, 1'b0, e);
      end
      if (abort >= 0) return;
      if (wr) begin
        m_count++;
        return;
      end
    end
    e = base(3'd5);
    e.cm = rw; e.pc = 1'b1; e.ins = 1'b1;
    step(1'b1, hlt, 1'b0, e);
    m_count++;
  endtask

  task automatic fetch_timeout();
    exp_t e;
    m_rd = 1'b0; m_wr = 1'b0; m_rw = 1'b1;
    for (int i = 0; i < int'(TO); i++) begin
      e = base(3'd1);
      e.fr = 1'b1;
      step(1'b0, 1'b0, 1'b0, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; io_halt = 1'b0; bus.io_bus_ready = 1'b0;
    io_memory_read_enable = 1'b0; io_memory_write_enable = 1'b0; io_reg_write_enable = 1'b0;
    m_count = 32'd0; m_rd = 1'b0; m_wr = 1'b0; m_rw = 1'b0;

    // ALU op from reset: 0,1,2,3,5 then next fetch
    do_reset(2);
    idle(1'b0);
    @(negedge clk); check("pin_idle_state", {29'd0, io_state}, 32'd0);
    instr(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);
    @(negedge clk);
    check("pin_wb_state",  {29'd0, io_state}, 32'd5);
    check("pin_wb_commit", {31'd0, io_reg_write_commit}, 32'd1);
    check("pin_wb_count",  io_instret_count, 32'd0);
    // Load with 3 wait cycles, store, branch, ALU with fetch accepted at cycle TO
    instr(1'b1, 1'b0, 1'b1, 0, 3, 1'b0, -1);
    instr(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, -1);
    instr(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    instr(1'b0, 1'b0, 1'b1, int'(TO) - 1, 0, 1'b0, -1);

    // Halt raised in EXECUTE: instruction completes, then HALTED
    instr(1'b0, 1'b0, 1'b1, 0, 0, 1'b1, -1);
    halted(1'b1);
    halted(1'b1);
    @(negedge clk);
    check("pin_halt_state", {29'd0, io_state}, 32'd6);
    check("pin_halt_count", io_instret_count, 32'd6);
    halted(1'b0);
    instr(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);

    // Store then branch from reset; branch retires into HALTED
    do_reset(1);
    idle(1'b0);
    instr(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, -1);
    instr(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, -1);
    halted(1'b0);
    @(negedge clk); check("pin_sb_count", io_instret_count, 32'd2);

    // Illegal read+write from decoder
    do_reset(1);
    idle(1'b0);
    instr(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, -1);
    err(3);
    @(negedge clk);
    check("pin_err_flag",  {31'd0, io_bus_error}, 32'd1);
    check("pin_err_count", io_instret_count, 32'd0);

    // Reset in the middle of a stalled load
    do_reset(1);
    idle(1'b0);
    instr(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);
    instr(1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 2);
    do_reset(1);
    @(negedge clk);
    check("pin_rst_data_req", {31'd0, bus.io_data_request}, 32'd0);
    check("pin_rst_count",    io_instret_count, 32'd0);
    idle(1'b0);
    instr(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);

    // Fetch timeout, then recovery through reset and IDLE->HALTED
    fetch_timeout();
    err(2);
    @(negedge clk); check("pin_to_state", {29'd0, io_state}, 32'd7);
    do_reset(1);
    idle(1'b1);
    @(negedge clk); check("pin_to_idle", {29'd0, io_state}, 32'd0);
    halted(1'b1);
    halted(1'b0);
    instr(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequencer for the multi-cycle RISC-V core; it steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Shares one memory bus port between instruction fetch and data access, using a request/ready handshake with a timeout.
- Consumes the control signals produced by the instruction decoder.
- Produces the per-phase enables (IR latch, register commit, PC update) and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 255, maximum consecutive request cycles without io_bus_ready before the unit enters ERROR (must be ≥1).

Ports:
- clock  input  1  core clock
- reset  input  1  synchronous, active-high reset
- io_halt  input  1  debug halt request
- io_memory_read_enable  input  1  decoder: load
- io_memory_write_enable  input  1  decoder: store
- io_reg_write_enable  input  1  decoder: rd write
- io_bus_ready  input  1  memory acknowledge for the current request
- io_fetch_request  output  1  instruction read request on the shared bus
- io_data_request  output  1  data access request on the shared bus
- io_data_write  output  1  data access is a store (valid only with io_data_request)
- io_ir_write_enable  output  1  latch the fetched instruction
- io_reg_write_commit  output  1  register-file write strobe
- io_pc_write_enable  output  1  PC update strobe (retire cycle)
- io_instret  output  1  one-cycle pulse per retired instruction
- io_instret_count  output  32  count of retired instructions
- io_state  output  3  current state encoding
- io_bus_error  output  1  sticky timeout flag

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6, ERROR=7.
- Reset:
  - state=IDLE; latched controls=0; wait counter=0; io_instret_count=0.
  - All outputs are 0 while reset is high, including outputs that depend combinationally on inputs.
  - Reset asserted mid-transaction abandons the transaction; requests are low in the reset cycle.
- IDLE: next state is HALTED if io_halt=1, else FETCH.
- FETCH:
  - io_fetch_request=1.
  - In the cycle io_bus_ready=1: io_ir_write_enable=1, and next state is DECODE.
- DECODE:
  - Exactly one cycle.
  - Captures io_memory_read_enable, io_memory_write_enable and io_reg_write_enable into internal registers at the end of the cycle.
  - Next state is EXECUTE.
- EXECUTE (one cycle), using the latched controls:
  - read=1 and write=1: next state is ERROR.
  - read=1 or write=1: next state is MEMORY.
  - Otherwise, reg_write=1: next state is WRITEBACK.
  - Otherwise: this is the retire cycle.
- MEMORY:
  - io_data_request=1; io_data_write equals the latched write control.
  - On io_bus_ready=1, load: next state is WRITEBACK.
  - On io_bus_ready=1, store: this is the retire cycle.
- WRITEBACK:
  - io_reg_write_commit equals the latched reg_write control.
  - This is the retire cycle.
- Retire cycle:
  - io_pc_write_enable=1 and io_instret=1.
  - io_instret_count increments at the end of the cycle and wraps from 0xFFFFFFFF to 0.
  - Next state is HALTED if io_halt=1, else FETCH.
  - io_halt is sampled only in the retire cycle and in IDLE; it never interrupts an instruction in flight.
- HALTED:
  - All strobes are 0.
  - The unit stays in HALTED while io_halt=1 and moves to FETCH in the cycle after io_halt=0.
- Timeout:
  - The wait counter clears on entering FETCH or MEMORY.
  - It increments in each FETCH/MEMORY cycle with io_bus_ready=0.
  - io_bus_ready is accepted in request cycle k for k ≤ MEM_TIMEOUT.
  - If ready stays low for MEM_TIMEOUT consecutive cycles, next state is ERROR.
- ERROR:
  - io_bus_error=1; all requests and strobes are 0.
  - The unit leaves ERROR only on reset.
- Shared bus: io_fetch_request and io_data_request are never both 1. A request holds steady until ready is seen.
- Latency with zero-wait memory:
  - ALU op with rd write: 4 cycles (F, D, E, WB).
  - Load: 5 cycles.
  - Store: 4 cycles, retiring in MEMORY.
  - Branch with no write: 3 cycles, retiring in EXECUTE.
- io_bus_ready outside FETCH/MEMORY is ignored.

Test Plan:
- ALU op (reg_write=1, mem=0), ready always 1, from reset release:
  - io_state sequence is 0,1,2,3,5,1.
  - io_ir_write_enable is high in the FETCH cycle.
  - io_reg_write_commit, io_pc_write_enable and io_instret are high in the WB cycle.
  - io_instret_count=1.
- Load with data ready delayed 3 cycles:
  - MEMORY lasts 4 cycles with io_data_request=1 and io_data_write=0.
  - Then WB commits; total instruction time is 8 cycles.
- Store, then branch (no write), ready=1:
  - Store retires in MEMORY with io_data_write=1 and io_reg_write_commit=0.
  - Branch retires in EXECUTE.
  - io_instret_count=2 after 7 cycles.
- MEM_TIMEOUT=4, ready held 0 in FETCH:
  - io_fetch_request is high for exactly 4 cycles, then io_state=7 and io_bus_error=1.
  - Both stay until reset, after which io_state=0.
- io_halt=1 asserted during EXECUTE of an ALU op:
  - The instruction completes WB, then io_state=6 with no fetch.
  - After io_halt drops, FETCH follows in the next cycle.
- Decoder drives read=1 and write=1 together: EXECUTE goes to ERROR, with no data request and no instret pulse. Separately, reset asserted mid-MEMORY: requests drop in the reset cycle and io_instret_count=0.
